// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Resolution stage for RISC-V conditional branches. It evaluates the branch
//   condition on the source operands, computes the correct next PC, and flags
//   whether the prediction carried from fetch was wrong. It also owns a table
//   of 2-bit saturating counters (BHT). Fetch reads the table combinationally
//   for prediction, and this block trains one entry on every resolved branch.
//
// Parameters:
//   XLEN       operand / PC width
//   BHT_DEPTH  number of BHT entries (power of 2, >= 2)
//   IDX_LSB    lowest PC bit of the BHT index; index = pc[IDX_LSB +: log2(BHT_DEPTH)]
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid, flush   request strobe / kill of request and pending output
//   in_opcode/funct3  instruction opcode and branch condition
//   in_pc, in_rs1, in_rs2, in_imm   branch PC, operands, sign-extended B-imm
//   in_pred_taken     direction predicted at fetch
//   pred_pc           fetch PC for the BHT lookup
//   pred_taken        combinational MSB of the indexed BHT counter
//   out_valid         one-cycle pulse per accepted request
//   out_taken         resolved direction
//   out_mispredict    resolved direction differs from in_pred_taken
//   out_redirect_pc   correct next PC
//   stat_branches     saturating count of accepted requests
//   stat_mispredicts  saturating count of mispredicted requests
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_LSB   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic            out_valid,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts
);

    localparam int         IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [15:0] STAT_MAX  = 16'hFFFF;

    // Handshake: there is no back-pressure. A request is taken whenever
    // in_valid=1 and flush=0 on a rising edge; the result appears on out_*
    // right after that edge and out_valid stays high for exactly one cycle.

    logic [1:0]      r_bht [BHT_DEPTH];
    logic            r_out_valid;
    logic            r_out_taken;
    logic            r_out_mispredict;
    logic [XLEN-1:0] r_out_redirect_pc;
    logic [15:0]     r_stat_branches;
    logic [15:0]     r_stat_mispredicts;

    logic            w_legal_f3;
    logic            w_accept;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_taken;
    logic            w_mispredict;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_redirect;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_pred_idx;
    logic [1:0]      w_cnt_cur;
    logic [1:0]      w_cnt_next;
    logic            w_pred_pc_unused;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_legal_f3 = 1'b0;
        case (in_funct3)
            3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: w_legal_f3 = 1'b1;
            default:                                        w_legal_f3 = 1'b0;
        endcase
    end

    assign w_accept = in_valid && !flush && (in_opcode == OPC_BRANCH) && w_legal_f3;

    // ------------------------------------------------------------- condition
    // Operands are compared directly at full width so that signed and
    // unsigned orderings stay correct even when the subtraction would overflow.
    assign w_eq   = (in_rs1 == in_rs2);
    assign w_lt_s = ($signed(in_rs1) < $signed(in_rs2));
    assign w_lt_u = (in_rs1 < in_rs2);

    always_comb begin
        w_taken = 1'b0;
        case (in_funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt_s;
            3'b101:  w_taken = !w_lt_s;
            3'b110:  w_taken = w_lt_u;
            3'b111:  w_taken = !w_lt_u;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_mispredict = (w_taken != in_pred_taken);

    // Both sums wrap modulo 2^XLEN; the carry out is intentionally dropped.
    assign w_target   = in_pc + in_imm;
    assign w_seq      = in_pc + XLEN'(4);
    assign w_redirect = w_taken ? w_target : w_seq;

    // ------------------------------------------------------------------- BHT
    assign w_upd_idx  = in_pc[IDX_LSB +: IDX_W];
    assign w_pred_idx = pred_pc[IDX_LSB +: IDX_W];

    // Only the index bits of pred_pc matter; the rest is folded away here.
    assign w_pred_pc_unused = ^pred_pc;

    // Counter read sees the value left by the previous edge, so back-to-back
    // requests to one entry chain correctly.
    assign w_cnt_cur = r_bht[w_upd_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_taken) begin
            if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept) begin
            r_bht[w_upd_idx] <= w_cnt_next;
        end
    end

    // Combinational lookup: a write at the coming edge is not yet visible.
    assign pred_taken = r_bht[w_pred_idx][1];

    // ---------------------------------------------------------------- result
    // flush clears the whole result; an idle cycle only drops out_valid and
    // leaves the last result fields in place.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_valid       <= 1'b0;
            r_out_taken       <= 1'b0;
            r_out_mispredict  <= 1'b0;
            r_out_redirect_pc <= '0;
        end else if (w_accept) begin
            r_out_valid       <= 1'b1;
            r_out_taken       <= w_taken;
            r_out_mispredict  <= w_mispredict;
            r_out_redirect_pc <= w_redirect;
        end else begin
            r_out_valid       <= 1'b0;
        end
    end

    // ------------------------------------------------------------ statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_accept) begin
            if (r_stat_branches != STAT_MAX) begin
                r_stat_branches <= r_stat_branches + 16'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != STAT_MAX)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign out_taken        = r_out_taken;
    assign out_mispredict   = r_out_mispredict;
    assign out_redirect_pc  = r_out_redirect_pc;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam logic [6:0] BR = 7'b1100011;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            flush;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            out_valid;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic [15:0]     stat_branches;
  logic [15:0]     stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .IDX_LSB(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  // ---------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ check helper
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  // Architectural view: counters as integers 0..3, stats as integers capped
  // at 65535, branch outcome from plain 64-bit signed/unsigned arithmetic.
  int              bht_m [DEPTH];
  int              st_br;
  int              st_mp;
  bit              started = 0;
  bit              exp_valid;
  bit              exp_zero;
  bit              exp_taken;
  bit              exp_mp;
  logic [XLEN-1:0] exp_pc;

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (f3)
      3'b000:  return ua == ub;
      3'b001:  return ua != ub;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  function automatic bit is_branch(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == BR) && (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
      st_br = 0;
      st_mp = 0;
      exp_valid = 0;
      exp_zero = 1;
      started = 1;
    end else if (flush) begin
      exp_valid = 0;
      exp_zero = 1;
    end else if (in_valid && is_branch(in_opcode, in_funct3)) begin
      longint sum;
      int k;
      exp_taken = model_taken(in_funct3, in_rs1, in_rs2);
      exp_mp = (exp_taken != in_pred_taken);
      sum = exp_taken ? (longint'({32'd0, in_pc}) + longint'({32'd0, in_imm}))
                      : (longint'({32'd0, in_pc}) + 4);
      exp_pc = sum[XLEN-1:0];
      exp_valid = 1;
      exp_zero = 0;
      k = idx_of(in_pc);
      if (exp_taken) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
      else           bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      if (st_br < 65535) st_br++;
      if (exp_mp && st_mp < 65535) st_mp++;
    end else begin
      exp_valid = 0;
    end
  end

  // ---------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        check("out_taken", out_taken, exp_taken);
        check("out_mispredict", out_mispredict, exp_mp);
        check("out_redirect_pc", out_redirect_pc, exp_pc);
      end else if (exp_zero) begin
        check("cleared_taken", out_taken, 0);
        check("cleared_mispredict", out_mispredict, 0);
        check("cleared_redirect", out_redirect_pc, 0);
      end
      check("stat_branches", stat_branches, st_br[15:0]);
      check("stat_mispredicts", stat_mispredicts, st_mp[15:0]);
      check("pred_taken", pred_taken, bht_m[idx_of(pred_pc)] >= 2);
    end
  end

  // ----------------------------------------------------------- driver tasks
  task automatic set_req(input bit v, input bit f, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] imm, input bit pt);
    in_valid = v;
    flush = f;
    in_opcode = opc;
    in_funct3 = f3;
    in_pc = pc;
    in_rs1 = a;
    in_rs2 = b;
    in_imm = imm;
    in_pred_taken = pt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] f3, input logic [XLEN-1:0] pc,
                    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                    input logic [XLEN-1:0] imm, input bit pt);
    set_req(1, 0, BR, f3, pc, a, b, imm, pt);
    step();
  endtask

  task automatic idle();
    set_req(0, 0, BR, 3'b000, '0, '0, '0, '0, 0);
    step();
  endtask

  task automatic chk_out(input string tag, input bit v, input bit t,
                         input logic [XLEN-1:0] pc);
    check({tag, "_valid"}, out_valid, v);
    check({tag, "_taken"}, out_taken, t);
    check({tag, "_redirect"}, out_redirect_pc, pc);
  endtask

  task automatic chk_stats(input string tag, input logic [15:0] b, input logic [15:0] m);
    check({tag, "_branches"}, stat_branches, b);
    check({tag, "_mispredicts"}, stat_mispredicts, m);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1;
    pred_pc = '0;
    set_req(0, 0, BR, 3'b000, '0, '0, '0, '0, 0);
    step();
    step();
    chk_out("reset", 0, 0, 32'h0);
    check("reset_mispredict", out_mispredict, 0);
    chk_stats("reset", 0, 0);
    reset = 0;

    for (int i = 0; i < DEPTH; i++) begin
      pred_pc = 32'(i * 4);
      step();
      check("reset_sweep_pred", pred_taken, 0);
    end
    pred_pc = 32'h8;

    // signedness: rs1=-1, rs2=1
    br(3'b100, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h40, 0);
    chk_out("blt", 1, 1, 32'h140);
    br(3'b110, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h40, 0);
    chk_out("bltu", 1, 0, 32'h104);
    br(3'b111, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h40, 0);
    chk_out("bgeu", 1, 1, 32'h140);
    br(3'b101, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h40, 0);
    chk_out("bge", 1, 0, 32'h104);
    chk_stats("signed", 4, 2);

    // training at pc 8, back to back
    set_req(1, 0, BR, 3'b000, 32'h8, 32'd5, 32'd5, 32'h20, 0);
    #1 check("train_pre_read", pred_taken, 0);
    step();
    chk_out("train1", 1, 1, 32'h28);
    check("train1_mp", out_mispredict, 1);
    check("train1_pred", pred_taken, 1);
    br(3'b000, 32'h8, 32'd5, 32'd5, 32'h20, 0);
    check("train2_mp", out_mispredict, 1);
    check("train2_pred", pred_taken, 1);
    br(3'b000, 32'h8, 32'd5, 32'd5, 32'h20, 0);
    check("train3_mp", out_mispredict, 1);
    check("train3_pred", pred_taken, 1);
    br(3'b000, 32'h8, 32'd5, 32'd6, 32'h20, 0);
    chk_out("train4", 1, 0, 32'hC);
    check("train4_mp", out_mispredict, 0);
    check("train4_pred_sat", pred_taken, 1);
    br(3'b000, 32'h8, 32'd5, 32'd6, 32'h20, 0);
    check("train5_pred", pred_taken, 0);
    chk_stats("train", 9, 5);

    // wrap-around
    br(3'b001, 32'hFFFFFFFC, 32'd7, 32'd7, 32'h40, 0);
    chk_out("wrap_nt", 1, 0, 32'h0);
    br(3'b000, 32'hFFFFFFF0, 32'd3, 32'd3, 32'h20, 1);
    chk_out("wrap_t", 1, 1, 32'h10);
    check("wrap_t_mp", out_mispredict, 0);

    // illegal requests
    br(3'b010, 32'h8, 32'd1, 32'd1, 32'h20, 0);
    check("illegal_f3_valid", out_valid, 0);
    chk_stats("illegal_f3", 11, 5);
    set_req(1, 0, 7'b0110011, 3'b000, 32'h8, 32'd1, 32'd1, 32'h20, 0);
    step();
    check("illegal_opc_valid", out_valid, 0);
    chk_stats("illegal_opc", 11, 5);

    // flush with request: dropped, BHT untouched
    set_req(1, 1, BR, 3'b000, 32'h8, 32'd1, 32'd1, 32'h20, 0);
    step();
    chk_out("flush_req", 0, 0, 32'h0);
    check("flush_req_pred", pred_taken, 0);
    chk_stats("flush_req", 11, 5);

    // flush alone clears a pending result
    br(3'b110, 32'h200, 32'd1, 32'd2, 32'h10, 1);
    chk_out("pre_flush", 1, 1, 32'h210);
    set_req(0, 1, BR, 3'b000, '0, '0, '0, '0, 0);
    step();
    chk_out("flush_only", 0, 0, 32'h0);
    idle();

    // reset with a request in flight
    reset = 1;
    set_req(1, 0, BR, 3'b000, 32'h8, 32'd1, 32'd1, 32'h20, 0);
    step();
    reset = 0;
    chk_out("reset_req", 0, 0, 32'h0);
    chk_stats("reset_req", 0, 0);
    check("reset_req_pred", pred_taken, 0);

    // BGE with a negative rs2 and negative offset
    br(3'b101, 32'h300, 32'd5, 32'hFFFFFFFD, 32'hFFFFFFF0, 0);
    chk_out("bge_neg", 1, 1, 32'h2F0);
    chk_stats("bge_neg", 1, 1);

    // statistics saturation
    pred_pc = 32'h10;
    for (int i = 0; i < 65540; i++) begin
      br(3'b000, 32'h10, 32'd9, 32'd9, 32'h8, 0);
    end
    chk_stats("sat", 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      br(3'b001, 32'h10, 32'd9, 32'd8, 32'h8, 0);
    end
    chk_stats("sat_hold", 16'hFFFF, 16'hFFFF);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
